multicycle_control_unit: RTL and testbench
==========================================

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter MEM_TIMEOUT, default 255: maximum wait cycles on a memory request before trapping; legal range 1..2^TMO_W-1.
REQ-002 Parameter TMO_W, default 8: width of the timeout counter.
REQ-003 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-004 clk  in  1: single clock; all state updates on the rising edge.
REQ-005 rst  in  1: asynchronous, active-high reset.
REQ-006 op  in  7: opcode from the instruction register. func3  in  3: instruction field. func7  in  7: instruction field.
REQ-007 Zero, Lt, Ltu  in  1 each: ALU flags from rs1-rs2 (equal, signed less-than, unsigned less-than).
REQ-008 mem_ready  in  1: memory completion strobe for the current request.
REQ-009 mem_req  out  1: memory request; AdrSrc  out  1: address source (0=PC, 1=ALU result).
REQ-010 IRWrite, PCWrite, RegWrite, MemWrite  out  1 each: write enables.
REQ-011 PCSrc  out  2: PC source (00=PC+4, 01=OldPC+imm, 10=ALU result&~1).
REQ-012 ALUSrcA  out  2: A source (00=rs1, 01=OldPC, 10=zero). ALUSrcB  out  1: B source (0=rs2, 1=imm).
REQ-013 ALUControl  out  4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU.
REQ-014 ImmSrc  out  3: 0=I, 1=S, 2=B, 3=U, 4=J. ResultSrc  out  2: 00=ALU, 01=memory, 10=OldPC+4.
REQ-015 Load  out  5: one-hot LB, LH, LW, LBU, LHU (bits 0..4). Store  out  3: one-hot SB, SH, SW.
REQ-016 state  out  3; trap  out  1; trap_cause  out  2; instret  out  CNT_W.

Function
REQ-017 States SHALL be FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; all unlisted outputs are 0 in every state.
REQ-018 FETCH: mem_req=1, AdrSrc=0. On mem_ready: IRWrite=1, PCWrite=1, PCSrc=00, go to DECODE.
REQ-019 DECODE: op outside {0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111}, an illegal load/store/branch func3, or an illegal R-type func7 -> TRAP with cause 1; otherwise go to EXEC.
REQ-020 EXEC, R/I-ALU: ALUControl from func3/func7; SRAI/SRA and SUB use func7[5]; SUB is R-type only.
REQ-021 EXEC, LUI: ALUSrcA=10, ImmSrc=3, ADD. EXEC, AUIPC: ALUSrcA=01, ImmSrc=3, ADD. Both go to WB.
REQ-022 EXEC, load/store: ALUSrcB=1, ADD, ImmSrc=0 for loads and 1 for stores; go to MEM.
REQ-023 EXEC, branch: ALUControl=SUB, ImmSrc=2. Taken if BEQ Zero, BNE !Zero, BLT Lt, BGE !Lt, BLTU Ltu, BGEU !Ltu. If taken: PCWrite=1, PCSrc=01. Retire and go to FETCH.
REQ-024 EXEC, JAL: PCWrite=1, PCSrc=01, ImmSrc=4; go to WB. EXEC, JALR: ALUSrcB=1, ADD, PCWrite=1, PCSrc=10; go to WB.
REQ-025 MEM: mem_req=1, AdrSrc=1, Load/Store one-hot per func3, MemWrite=1 for stores. On mem_ready: loads go to WB; stores retire and go to FETCH.
REQ-026 WB: RegWrite=1; ResultSrc=01 for loads, 10 for JAL/JALR, 00 otherwise. Retire and go to FETCH.
REQ-027 mem_req, AdrSrc, Load and Store SHALL stay stable until mem_ready is seen.
REQ-028 The timeout counter clears on entry to FETCH/MEM and increments each cycle mem_ready=0. On reaching MEM_TIMEOUT -> TRAP, cause 2. mem_ready in the same cycle as the limit wins.
REQ-029 TRAP: trap=1 and all enables 0; held until rst. trap_cause SHALL be 0 outside TRAP.
REQ-030 instret SHALL increment by 1 on each retire and wrap modulo 2^CNT_W.
REQ-031 Outputs SHALL be decoded from the registered state plus the inputs; no combinational path from mem_ready to mem_req.

Reset
REQ-032 rst=1 SHALL immediately force state=FETCH, instret=0, trap=0, trap_cause=0 and the timeout counter to 0, including mid-memory-request.
REQ-033 After rst deasserts, the first rising edge begins a FETCH with mem_req=1.

Verification
REQ-034 ADD x3,x1,x2 with mem_ready=1 on the first FETCH cycle -> states 0,1,2,4,0; RegWrite=1 only in WB; instret 0->1.
REQ-035 BEQ with Zero=1 -> PCWrite=1, PCSrc=01 in EXEC, no WB. BNE with Zero=1 -> PCWrite=0 in EXEC. instret +1 each.
REQ-036 LW with mem_ready delayed 3 cycles in MEM -> mem_req and Load=00100 held 4 cycles, then WB with ResultSrc=01.
REQ-037 mem_ready held 0 in FETCH with MEM_TIMEOUT=4 -> TRAP after 4 wait cycles, trap_cause=2; stays there until rst.
REQ-038 op=0000000 -> TRAP from DECODE, trap_cause=1. Assert rst mid-MEM -> state=0 asynchronously. CNT_W=4 after 16 retires -> instret=0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback,
// traps on illegal instructions or memory timeouts, and counts retired instructions.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned TMO_W       = 8,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       op,
  input  logic [2:0]       func3,
  input  logic [6:0]       func7,
  input  logic             Zero,
  input  logic             Lt,
  input  logic             Ltu,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             AdrSrc,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [1:0]       PCSrc,
  output logic [1:0]       ALUSrcA,
  output logic             ALUSrcB,
  output logic [3:0]       ALUControl,
  output logic [2:0]       ImmSrc,
  output logic [1:0]       ResultSrc,
  output logic [4:0]       Load,
  output logic [2:0]       Store,
  output logic [2:0]       state,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2,
    S_MEM   = 3'd3, S_WB     = 3'd4, S_TRAP = 3'd5
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                         ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
  localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;

  state_t           state_q, state_d;
  logic [TMO_W-1:0] tmo_q;
  logic [1:0]       cause_q;

  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic illegal, tmo_hit, br_taken, retire;
  logic [3:0] alu_ri;
  logic [4:0] ld_onehot;
  logic [2:0] st_onehot;

  // Instruction classification and legality
  always_comb begin
    is_r     = (op == 7'b0110011);
    is_i     = (op == 7'b0010011);
    is_ld    = (op == 7'b0000011);
    is_st    = (op == 7'b0100011);
    is_br    = (op == 7'b1100011);
    is_jal   = (op == 7'b1101111);
    is_jalr  = (op == 7'b1100111);
    is_lui   = (op == 7'b0110111);
    is_auipc = (op == 7'b0010111);
    illegal  = !(is_r || is_i || is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_auipc)
            || (is_ld && !(func3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            || (is_st && !(func3 inside {3'b000, 3'b001, 3'b010}))
            || (is_br && (func3 inside {3'b010, 3'b011}))
            || (is_r && !((func7 == 7'b0000000) ||
                          (func7 == 7'b0100000 && (func3 == 3'b000 || func3 == 3'b101))));
  end

  // ALU op for register/immediate arithmetic, branch outcome, memory lane selects
  always_comb begin
    alu_ri = ALU_ADD;
    case (func3)
      3'b000:  alu_ri = (is_r && func7[5]) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ri = ALU_SLL;
      3'b010:  alu_ri = ALU_SLT;
      3'b011:  alu_ri = ALU_SLTU;
      3'b100:  alu_ri = ALU_XOR;
      3'b101:  alu_ri = func7[5] ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ri = ALU_OR;
      default: alu_ri = ALU_AND;
    endcase
    br_taken = 1'b0;
    case (func3)
      3'b000:  br_taken = Zero;
      3'b001:  br_taken = !Zero;
      3'b100:  br_taken = Lt;
      3'b101:  br_taken = !Lt;
      3'b110:  br_taken = Ltu;
      3'b111:  br_taken = !Ltu;
      default: br_taken = 1'b0;
    endcase
    ld_onehot = 5'b00000;
    case (func3)
      3'b000:  ld_onehot = 5'b00001;
      3'b001:  ld_onehot = 5'b00010;
      3'b010:  ld_onehot = 5'b00100;
      3'b100:  ld_onehot = 5'b01000;
      3'b101:  ld_onehot = 5'b10000;
      default: ld_onehot = 5'b00000;
    endcase
    st_onehot = 3'b000;
    case (func3)
      3'b000:  st_onehot = 3'b001;
      3'b001:  st_onehot = 3'b010;
      3'b010:  st_onehot = 3'b100;
      default: st_onehot = 3'b000;
    endcase
  end

  assign tmo_hit = !mem_ready && (tmo_q == TMO_W'(MEM_TIMEOUT - 1));
  assign retire  = (state_q == S_EXEC && is_br) || (state_q == S_MEM && is_st && mem_ready)
                || (state_q == S_WB);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (mem_ready) state_d = S_DECODE;
                else if (tmo_hit) state_d = S_TRAP;
      S_DECODE: state_d = illegal ? S_TRAP : S_EXEC;
      S_EXEC:   if (is_ld || is_st) state_d = S_MEM;
                else if (is_br) state_d = S_FETCH;
                else state_d = S_WB;
      S_MEM:    if (mem_ready) state_d = is_st ? S_FETCH : S_WB;
                else if (tmo_hit) state_d = S_TRAP;
      S_WB:     state_d = S_FETCH;
      S_TRAP:   state_d = S_TRAP;
      default:  state_d = S_FETCH;
    endcase
  end

  // Output decode from registered state plus current inputs
  always_comb begin
    mem_req    = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    MemWrite   = 1'b0;
    PCSrc      = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 1'b0;
    ALUControl = ALU_ADD;
    ImmSrc     = IMM_I;
    ResultSrc  = 2'b00;
    Load       = 5'b00000;
    Store      = 3'b000;
    trap       = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
        end
      end
      S_EXEC: begin
        // LUI/AUIPC take their immediate through operand B
        if (is_r || is_i) begin
          ALUControl = alu_ri;
          ALUSrcB    = is_i;
        end else if (is_lui) begin
          ALUSrcA = 2'b10; ALUSrcB = 1'b1; ImmSrc = IMM_U;
        end else if (is_auipc) begin
          ALUSrcA = 2'b01; ALUSrcB = 1'b1; ImmSrc = IMM_U;
        end else if (is_ld) begin
          ALUSrcB = 1'b1;
        end else if (is_st) begin
          ALUSrcB = 1'b1; ImmSrc = IMM_S;
        end else if (is_br) begin
          ALUControl = ALU_SUB; ImmSrc = IMM_B;
          if (br_taken) begin
            PCWrite = 1'b1; PCSrc = 2'b01;
          end
        end else if (is_jal) begin
          PCWrite = 1'b1; PCSrc = 2'b01; ImmSrc = IMM_J;
        end else if (is_jalr) begin
          ALUSrcB = 1'b1; PCWrite = 1'b1; PCSrc = 2'b10;
        end
      end
      S_MEM: begin
        mem_req  = 1'b1;
        AdrSrc   = 1'b1;
        Load     = is_ld ? ld_onehot : 5'b00000;
        Store    = is_st ? st_onehot : 3'b000;
        MemWrite = is_st;
      end
      S_WB: begin
        RegWrite  = 1'b1;
        ResultSrc = is_ld ? 2'b01 : ((is_jal || is_jalr) ? 2'b10 : 2'b00);
      end
      S_TRAP:  trap = 1'b1;
      default: trap = 1'b0;
    endcase
  end

  // Wait-cycle timer, trap cause capture, retired-instruction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q   <= '0;
      cause_q <= 2'd0;
      instret <= '0;
    end else begin
      if (state_d == state_q && (state_q == S_FETCH || state_q == S_MEM)) tmo_q <= tmo_q + TMO_W'(1);
      else tmo_q <= '0;
      if (state_d == S_TRAP && state_q != S_TRAP) cause_q <= (state_q == S_DECODE) ? 2'd1 : 2'd2;
      if (retire) instret <= instret + CNT_W'(1);
    end
  end

  assign state      = state_q;
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized self-checking bench for multicycle_control_unit against an
// instruction-level reference model (MEM_TIMEOUT=4, CNT_W=4).
module tb_multicycle_control_unit;
  localparam int TMO = 4;

  logic clk = 1'b0, rst;
  logic [6:0] op, func7;
  logic [2:0] func3;
  logic Zero, Lt, Ltu, mem_ready;
  logic mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, ALUSrcB, trap;
  logic [1:0] PCSrc, ALUSrcA, ResultSrc, trap_cause;
  logic [3:0] ALUControl, instret;
  logic [2:0] ImmSrc, Store, state;
  logic [4:0] Load;

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .TMO_W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .op(op), .func3(func3), .func7(func7), .Zero(Zero), .Lt(Lt),
    .Ltu(Ltu), .mem_ready(mem_ready), .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .PCSrc(PCSrc),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .ResultSrc(ResultSrc), .Load(Load), .Store(Store), .state(state), .trap(trap),
    .trap_cause(trap_cause), .instret(instret));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [3:0] exp_instret;

  logic [2:0] e_state, e_imm, e_st;
  logic e_mem_req, e_adr, e_irw, e_pcw, e_regw, e_memw, e_asb, e_trap;
  logic [1:0] e_pcsrc, e_asa, e_res, e_cause;
  logic [3:0] e_alu;
  logic [4:0] e_ld;
  logic [33:0] obs, expv, msk;

  assign obs  = {state, mem_req, AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, PCSrc, ALUSrcA,
                 ALUSrcB, ALUControl, ImmSrc, ResultSrc, Load, Store, trap, trap_cause};
  assign expv = {e_state, e_mem_req, e_adr, e_irw, e_pcw, e_regw, e_memw, e_pcsrc, e_asa,
                 e_asb, e_alu, e_imm, e_res, e_ld, e_st, e_trap, e_cause};

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LD = 3, K_ST = 4, K_BR = 5,
                 K_JAL = 6, K_JALR = 7, K_LUI = 8, K_AUIPC = 9;
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_T = 5, P_RET = 8, P_END = 9;

  function automatic int kind_of(logic [6:0] o, logic [2:0] f3, logic [6:0] f7);
    case (o)
      7'b0110011: return (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) ? K_R : K_ILL;
      7'b0010011: return K_I;
      7'b0000011: return (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) ? K_ILL : K_LD;
      7'b0100011: return (f3 <= 3'd2) ? K_ST : K_ILL;
      7'b1100011: return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      default:    return K_ILL;
    endcase
  endfunction

  // Mnemonic-table ALU code: ADD SLL SLT SLTU XOR SRL OR AND, with SUB/SRA variants
  function automatic logic [3:0] alu_code(int k, logic [2:0] f3, logic [6:0] f7);
    int tab [8] = '{0, 5, 8, 9, 4, 6, 3, 2};
    int r = tab[f3];
    if (f3 == 3'd5 && f7[5]) r = 7;
    if (f3 == 3'd0 && k == K_R && f7[5]) r = 1;
    return 4'(r);
  endfunction

  function automatic bit taken(logic [2:0] f3, logic z, logic l, logic lu);
    case (f3)
      3'd0: return z;   3'd1: return !z;
      3'd4: return l;   3'd5: return !l;
      3'd6: return lu;  default: return !lu;
    endcase
  endfunction

  task automatic clr_exp();
    {e_state, e_mem_req, e_adr, e_irw, e_pcw, e_regw, e_memw, e_pcsrc, e_asa, e_asb, e_alu,
     e_imm, e_res, e_ld, e_st, e_trap, e_cause} = '0;
    msk = '1;
  endtask

  // Execute one instruction end to end; fw/mw are wait cycles before mem_ready (-1 = never)
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                           input logic z, input logic l, input logic lu, input int fw,
                           input int mw, input string nm, output bit trapped);
    int k, ph, nxt, waitc, guard;
    logic [1:0] tc;
    bit rdy;
    k = kind_of(o, f3, f7);
    op = o; func3 = f3; func7 = f7; Zero = z; Lt = l; Ltu = lu;
    ph = P_F; waitc = 0; guard = 0; trapped = 0; tc = 2'd0;
    while (ph != P_END) begin
      if (guard++ > 40) begin
        checks++; failures++;
        $display("FAIL %s bound: stuck in phase %0d, required completion", nm, ph);
        break;
      end
      clr_exp();
      mem_ready = 1'b0;
      nxt = P_END;
      case (ph)
        P_F: begin
          e_state = 3'd0; e_mem_req = 1'b1;
          rdy = (fw >= 0 && waitc == fw);
          mem_ready = rdy;
          if (rdy) begin e_irw = 1'b1; e_pcw = 1'b1; nxt = P_D; end
          else if (waitc == TMO - 1) begin nxt = P_T; tc = 2'd2; end
          else nxt = P_F;
        end
        P_D: begin
          e_state = 3'd1;
          if (k == K_ILL) begin nxt = P_T; tc = 2'd1; end else nxt = P_E;
        end
        P_E: begin
          e_state = 3'd2; nxt = P_W;
          case (k)
            K_R:     e_alu = alu_code(k, f3, f7);
            K_I:     begin e_alu = alu_code(k, f3, f7); msk[20] = 1'b0; end
            K_LUI:   begin e_asa = 2'd2; e_imm = 3'd3; msk[20] = 1'b0; end
            K_AUIPC: begin e_asa = 2'd1; e_imm = 3'd3; msk[20] = 1'b0; end
            K_LD:    begin e_asb = 1'b1; nxt = P_M; end
            K_ST:    begin e_asb = 1'b1; e_imm = 3'd1; nxt = P_M; end
            K_BR: begin
              e_alu = 4'd1; e_imm = 3'd2; nxt = P_RET; exp_instret++;
              if (taken(f3, z, l, lu)) begin e_pcw = 1'b1; e_pcsrc = 2'd1; end
            end
            K_JAL:   begin e_pcw = 1'b1; e_pcsrc = 2'd1; e_imm = 3'd4; end
            default: begin e_asb = 1'b1; e_pcw = 1'b1; e_pcsrc = 2'd2; end
          endcase
        end
        P_M: begin
          e_state = 3'd3; e_mem_req = 1'b1; e_adr = 1'b1;
          if (k == K_LD) e_ld = 5'(1 << ((f3 > 3'd2) ? f3 - 3'd1 : f3));
          else begin e_st = 3'(1 << f3); e_memw = 1'b1; end
          rdy = (mw >= 0 && waitc == mw);
          mem_ready = rdy;
          if (rdy) begin
            nxt = (k == K_ST) ? P_RET : P_W;
            if (k == K_ST) exp_instret++;
          end else if (waitc == TMO - 1) begin nxt = P_T; tc = 2'd2; end
          else nxt = P_M;
        end
        P_W: begin
          e_state = 3'd4; e_regw = 1'b1; nxt = P_RET; exp_instret++;
          e_res = (k == K_LD) ? 2'd1 : ((k == K_JAL || k == K_JALR) ? 2'd2 : 2'd0);
        end
        P_T: begin
          e_state = 3'd5; e_trap = 1'b1; e_cause = tc; trapped = 1;
          mem_ready = 1'($urandom_range(0, 1));
        end
        default: begin
          e_state = 3'd0; e_mem_req = 1'b1;
        end
      endcase
      #1;
      checks++;
      if ((obs & msk) !== (expv & msk)) begin
        failures++;
        $display("FAIL %s phase %0d: got %h required %h", nm, ph, obs & msk, expv & msk);
      end
      if (ph == P_RET) begin
        checks++;
        if (instret !== exp_instret) begin
          failures++;
          $display("FAIL %s instret: got %0d required %0d", nm, instret, exp_instret);
        end
      end
      if (nxt != P_END) begin
        @(negedge clk);
        waitc = (nxt == ph) ? waitc + 1 : 0;
      end
      ph = nxt;
    end
  endtask

  task automatic gen_legal(output logic [6:0] o, output logic [2:0] f3, output logic [6:0] f7);
    for (int t = 0; t < 64; t++) begin
      case ($urandom_range(0, 8))
        0: o = 7'b0110011; 1: o = 7'b0010011; 2: o = 7'b0000011;
        3: o = 7'b0100011; 4: o = 7'b1100011; 5: o = 7'b1101111;
        6: o = 7'b1100111; 7: o = 7'b0110111; default: o = 7'b0010111;
      endcase
      f3 = 3'($urandom_range(0, 7));
      f7 = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
      if (kind_of(o, f3, f7) != K_ILL) return;
    end
    o = 7'b0110011; f3 = 3'd0; f7 = 7'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1; mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_instret = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_ready = 1'b0; op = 7'd0; func3 = 3'd0; func7 = 7'd0;
    Zero = 1'b0; Lt = 1'b0; Ltu = 1'b0;
    #2;
    checks++;
    if ({state, trap, trap_cause, instret} !== 10'd0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", {state, trap, trap_cause, instret});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0; exp_instret = 4'd0;
    #1;
    checks++;
    if (state !== 3'd0 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch: got state=%0d mem_req=%b required 0/1", state, mem_req);
    end
  endtask

  task automatic test_add();
    bit tr;
    run_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, "add", tr);
  endtask

  task automatic test_branch();
    bit tr;
    run_instr(7'b1100011, 3'd0, 7'h00, 1'b1, 1'b0, 1'b0, 0, 0, "beq_taken", tr);
    run_instr(7'b1100011, 3'd1, 7'h00, 1'b1, 1'b0, 1'b0, 1, 0, "bne_not_taken", tr);
    run_instr(7'b1100011, 3'd7, 7'h00, 1'b0, 1'b1, 1'b0, 0, 0, "bgeu_taken", tr);
  endtask

  task automatic test_lw_delay();
    bit tr;
    run_instr(7'b0000011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 1, 3, "lw_delay3", tr);
    run_instr(7'b0100011, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 3, 3, "sb_at_limit", tr);
  endtask

  task automatic test_fetch_timeout();
    bit tr;
    run_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, -1, 0, "fetch_timeout", tr);
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if ({state, trap, trap_cause, mem_req, IRWrite, PCWrite, RegWrite, MemWrite} !==
          {3'd5, 1'b1, 2'd2, 5'b00000}) begin
        failures++;
        $display("FAIL trap_hold: got state=%0d trap=%b cause=%0d required 5/1/2",
                 state, trap, trap_cause);
      end
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_mem_timeout();
    bit tr;
    run_instr(7'b0000011, 3'd4, 7'h00, 1'b0, 1'b0, 1'b0, 0, -1, "mem_timeout", tr);
    do_reset();
  endtask

  task automatic test_illegal();
    bit tr;
    run_instr(7'b0000000, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, "illegal_op", tr);
    do_reset();
    run_instr(7'b0110011, 3'd1, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, "illegal_rf7", tr);
    do_reset();
    run_instr(7'b0000011, 3'd3, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, "illegal_ld", tr);
    do_reset();
    run_instr(7'b1100011, 3'd2, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, "illegal_br", tr);
    do_reset();
  endtask

  task automatic test_reset_mid_mem();
    bit tr;
    run_instr(7'b0110011, 3'd0, 7'h00, 1'b0, 1'b0, 1'b0, 0, 0, "pre_add", tr);
    run_instr(7'b0010011, 3'd5, 7'h20, 1'b0, 1'b0, 1'b0, 0, 0, "pre_srai", tr);
    op = 7'b0000011; func3 = 3'd2; func7 = 7'h00; mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (state !== 3'd3 || mem_req !== 1'b1) begin
      failures++;
      $display("FAIL mid_mem_entry: got state=%0d mem_req=%b required 3/1", state, mem_req);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (state !== 3'd0 || instret !== 4'd0 || trap !== 1'b0 || trap_cause !== 2'd0) begin
      failures++;
      $display("FAIL async_reset: got state=%0d instret=%0d trap=%b required 0/0/0",
               state, instret, trap);
    end
    @(negedge clk);
    rst = 1'b0; exp_instret = 4'd0;
  endtask

  task automatic test_wrap();
    bit tr;
    logic [6:0] o, f7;
    logic [2:0] f3;
    for (int i = 0; i < 16; i++) begin
      gen_legal(o, f3, f7);
      run_instr(o, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), "wrap", tr);
    end
    checks++;
    if (instret !== 4'd0) begin
      failures++;
      $display("FAIL instret_wrap: got %0d required 0", instret);
    end
  endtask

  task automatic test_random();
    bit tr;
    logic [6:0] o, f7;
    logic [2:0] f3;
    for (int i = 0; i < 40; i++) begin
      gen_legal(o, f3, f7);
      run_instr(o, f3, f7, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3), "random", tr);
      if (tr) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_lw_delay();
    test_fetch_timeout();
    test_mem_timeout();
    test_illegal();
    test_reset_mid_mem();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
